// File: rtl/mfp_pkg.sv
// Shared register map, constants and IACK state type for the MFP interrupt controller.
package mfp_pkg;

    localparam logic [2:0] REG_IER  = 3'd0;
    localparam logic [2:0] REG_IPR  = 3'd1;
    localparam logic [2:0] REG_ISR  = 3'd2;
    localparam logic [2:0] REG_IMR  = 3'd3;
    localparam logic [2:0] REG_VR   = 3'd4;
    localparam logic [2:0] REG_MODE = 3'd5;
    localparam logic [2:0] REG_POL  = 3'd6;

    localparam logic [7:0] SPURIOUS_VEC = 8'h18;
    localparam int         VR_S_BIT     = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } iack_state_e;

endpackage

// File: rtl/mfp_prio_enc.sv
// Combinational highest-set-bit encoder: valid flag, index and one-hot of the top request.
module mfp_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    output logic                 valid,
    output logic [$clog2(N)-1:0] index,
    output logic [N-1:0]         onehot
);

    localparam int W = $clog2(N);

    // A bit survives only if nothing above it is requesting.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_top
            if (gi == N - 1) begin : g_msb
                assign onehot[gi] = req[gi];
            end else begin : g_lower
                assign onehot[gi] = req[gi] & ~(|req[N-1:gi+1]);
            end
        end
    endgenerate

    assign valid = |req;

    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                index = index | W'(i);
            end
        end
    end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// Vectored MFP-style interrupt controller: per-channel edge/level detection, IER/IPR/IMR/ISR,
// nested priority and a 68000 IACK/DTACK cycle.
module mfp_irq_ctrl
    import mfp_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [2:0]         reg_addr,
    input  logic               reg_we,
    input  logic [NUM_IRQ-1:0] reg_wdata,
    output logic [NUM_IRQ-1:0] reg_rdata,
    output logic               irq,
    input  logic               iack,
    output logic               dtack,
    output logic [7:0]         vec
);

    localparam int         IDX_W    = $clog2(NUM_IRQ);
    localparam logic [7:0] IDX_MASK = 8'((1 << IDX_W) - 1);

    logic [NUM_IRQ-1:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d, mode_q, mode_d, pol_q, pol_d;
    logic [7:0]         vr_q, vr_d, vec_q, vec_d;
    logic [NUM_IRQ-1:0] s_prev_q, s_prev_d;
    logic               irq_q, irq_d, dtack_q, dtack_d, iack_q, iack_d;
    iack_state_e        state_q, state_d;

    logic [NUM_IRQ-1:0] src_sync, s_vec, set_vec;
    logic [NUM_IRQ-1:0] ipr_clr, ier_dis, isr_keep, isr_set;
    logic               service, iack_rise;

    logic               p_valid, s_valid;
    logic [IDX_W-1:0]   p_idx, s_idx;
    logic [NUM_IRQ-1:0] p_onehot, isr_onehot_unused;

    // ---------------- source synchroniser ----------------
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign src_sync = irq_src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = irq_src;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign src_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Polarity folds into the source, so a POL or MODE write can itself produce an edge.
    assign s_vec    = src_sync ^ ~pol_q;
    assign s_prev_d = s_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            assign set_vec[gi] = ier_q[gi] & s_vec[gi] & (mode_q[gi] | ~s_prev_q[gi]);
        end
    endgenerate

    // ---------------- priority ----------------
    mfp_prio_enc #(.N(NUM_IRQ)) u_pend_enc (
        .req    (ipr_q & imr_q),
        .valid  (p_valid),
        .index  (p_idx),
        .onehot (p_onehot)
    );

    // Only the index of the in-service channel matters for nesting.
    mfp_prio_enc #(.N(NUM_IRQ)) u_isr_enc (
        .req    (isr_q),
        .valid  (s_valid),
        .index  (s_idx),
        .onehot (isr_onehot_unused)
    );

    assign irq_d     = p_valid && (!s_valid || (p_idx > s_idx));
    assign iack_d    = iack;
    assign iack_rise = iack && !iack_q;

    // ---------------- IACK sequencer ----------------
    always_comb begin
        state_d = state_q;
        dtack_d = dtack_q;
        service = 1'b0;
        case (state_q)
            IDLE: begin
                if (iack_rise) begin
                    state_d = ACK;
                    dtack_d = 1'b1;
                    service = 1'b1;
                end
            end
            ACK: begin
                dtack_d = iack;
                state_d = iack ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!iack) begin
                    state_d = IDLE;
                    dtack_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                dtack_d = 1'b0;
            end
        endcase
    end

    // ---------------- register file ----------------
    always_comb begin
        ier_d    = ier_q;
        imr_d    = imr_q;
        vr_d     = vr_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        vec_d    = vec_q;
        ipr_clr  = '0;
        ier_dis  = '0;
        isr_keep = '1;
        isr_set  = '0;

        if (service) begin
            if (p_valid) begin
                vec_d   = (vr_q & ~IDX_MASK) | 8'(p_idx);
                ipr_clr = p_onehot;
                if (vr_q[VR_S_BIT]) begin
                    isr_set = p_onehot;
                end
            end else begin
                vec_d = SPURIOUS_VEC;
            end
        end

        if (reg_we) begin
            case (reg_addr)
                REG_IER: begin
                    ier_d   = reg_wdata;
                    ier_dis = ~reg_wdata;
                end
                REG_IPR:  ipr_clr = ipr_clr | ~reg_wdata;
                REG_ISR: begin
                    if (vr_q[VR_S_BIT]) begin
                        isr_keep = reg_wdata;
                    end
                end
                REG_IMR:  imr_d  = reg_wdata;
                REG_VR:   vr_d   = 8'(reg_wdata);
                REG_MODE: mode_d = reg_wdata;
                REG_POL:  pol_d  = reg_wdata;
                default: ;
            endcase
        end

        // A fresh set beats any clear, except disabling the channel through IER.
        ipr_d = ((ipr_q & ~ipr_clr) | set_vec) & ~ier_dis;
        isr_d = (isr_q & isr_keep) | isr_set;
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_IER:  reg_rdata = ier_q;
            REG_IPR:  reg_rdata = ipr_q;
            REG_ISR:  reg_rdata = isr_q;
            REG_IMR:  reg_rdata = imr_q;
            REG_VR:   reg_rdata = NUM_IRQ'(vr_q);
            REG_MODE: reg_rdata = mode_q;
            REG_POL:  reg_rdata = pol_q;
            default:  reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ier_q    <= '0;
            ipr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= '0;
            mode_q   <= '0;
            pol_q    <= '0;
            vr_q     <= '0;
            vec_q    <= '0;
            s_prev_q <= '0;
            irq_q    <= 1'b0;
            dtack_q  <= 1'b0;
            iack_q   <= 1'b0;
            state_q  <= IDLE;
        end else begin
            ier_q    <= ier_d;
            ipr_q    <= ipr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            vr_q     <= vr_d;
            vec_q    <= vec_d;
            s_prev_q <= s_prev_d;
            irq_q    <= irq_d;
            dtack_q  <= dtack_d;
            iack_q   <= iack_d;
            state_q  <= state_d;
        end
    end

    assign irq   = irq_q;
    assign dtack = dtack_q;
    assign vec   = vec_q;

endmodule
